// File: rtl/ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle controller: opcode patterns,
// ALU operation codes (also used by the ALU), FSM states and instruction classes.
package ctrl_pkg;

    // Full 11-bit opcodes taken from instr[31:21]
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    // Short-opcode formats: CBZ matches instr[31:24], B matches instr[31:26]
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    // ALU operation codes
    localparam logic [1:0]  ALU_ADD  = 2'b00;
    localparam logic [1:0]  ALU_SUB  = 2'b01;
    localparam logic [1:0]  ALU_AND  = 2'b10;
    localparam logic [1:0]  ALU_ORR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_AND,
        CLS_ORR,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B
    } instr_class_t;

    // ALU operation for a class; address and branch classes use add
    function automatic logic [1:0] alu_op_for(input instr_class_t cls);
        case (cls)
            CLS_SUB: alu_op_for = ALU_SUB;
            CLS_AND: alu_op_for = ALU_AND;
            CLS_ORR: alu_op_for = ALU_ORR;
            default: alu_op_for = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: maps the instruction's top 11 bits to an
// instruction class and flags anything not in the supported subset.
module instr_class_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output instr_class_t       cls,
    output logic               illegal
);

    logic [10:0] opc;
    // Operand fields do not affect classification
    logic        unused_operands;

    assign opc             = instr[INSTR_W-1 -: 11];
    assign unused_operands = ^instr[INSTR_W-12:0];

    // Full opcodes first, then the short-opcode branch formats
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        cls     = CLS_ADD;
        illegal = 1'b0;
        case (opc)
            OPC_ADD:  cls = CLS_ADD;
            OPC_SUB:  cls = CLS_SUB;
            OPC_AND:  cls = CLS_AND;
            OPC_ORR:  cls = CLS_ORR;
            OPC_LDUR: cls = CLS_LDUR;
            OPC_STUR: cls = CLS_STUR;
            default: begin
                if (opc[10:3] == OPC_CBZ) begin
                    cls = CLS_CBZ;
                end else if (opc[10:5] == OPC_B) begin
                    cls = CLS_B;
                end else begin
                    illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshake stalls, CBZ resolution from the ALU zero flag and an
// illegal-opcode trap state left only through reset.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               memReady,
    input  logic               isZero,
    output logic [1:0]         ALUop,
    output logic               aluSrc,
    output logic               reg2Loc,
    output logic               irWrite,
    output logic               pcWrite,
    output logic               pcSrc,
    output logic               memRead,
    output logic               memWrite,
    output logic               memToReg,
    output logic               regWrite,
    output logic               halted
);

    state_t       state_q;
    instr_class_t class_q;
    instr_class_t class_d;
    logic         illegal_d;

    instr_class_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .instr   (instr),
        .cls     (class_d),
        .illegal (illegal_d)
    );

    // State register and latched instruction class, synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            class_q <= CLS_ADD;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= S_FETCH;
                S_FETCH:  if (memReady) state_q <= S_DECODE;
                S_DECODE: begin
                    class_q <= class_d;
                    state_q <= illegal_d ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    case (class_q)
                        CLS_LDUR, CLS_STUR: state_q <= S_MEM;
                        CLS_CBZ, CLS_B:     state_q <= S_FETCH;
                        default:            state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (memReady) begin
                        state_q <= (class_q == CLS_LDUR) ? S_WB : S_FETCH;
                    end
                end
                S_WB:     state_q <= S_FETCH;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode from state and latched class; FETCH completion strobes follow
    // memReady and the CBZ PC update follows isZero within the same cycle
    always_comb begin
        ALUop    = ALU_ADD;
        aluSrc   = 1'b0;
        reg2Loc  = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                end
            end
            S_EXEC: begin
                ALUop = alu_op_for(class_q);
                case (class_q)
                    CLS_LDUR, CLS_STUR: aluSrc = 1'b1;
                    CLS_CBZ: begin
                        reg2Loc = 1'b1;
                        pcWrite = isZero;
                        pcSrc   = isZero;
                    end
                    CLS_B: begin
                        pcWrite = 1'b1;
                        pcSrc   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (class_q == CLS_LDUR) begin
                    memRead = 1'b1;
                end else begin
                    memWrite = 1'b1;
                    reg2Loc  = 1'b1;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                memToReg = (class_q == CLS_LDUR);
            end
            S_TRAP: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process drives one cycle
// at a time and queues the hand-computed output vector for that cycle; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

  // Packed output vector layout: [11:10] ALUop, then one bit per strobe
  localparam logic [11:0] Z      = 12'h000;
  localparam logic [11:0] HALT   = 12'h001;
  localparam logic [11:0] REGW   = 12'h002;
  localparam logic [11:0] M2R    = 12'h004;
  localparam logic [11:0] MEMW   = 12'h008;
  localparam logic [11:0] MEMR   = 12'h010;
  localparam logic [11:0] PCSRC  = 12'h020;
  localparam logic [11:0] PCW    = 12'h040;
  localparam logic [11:0] IRW    = 12'h080;
  localparam logic [11:0] R2L    = 12'h100;
  localparam logic [11:0] ALUSRC = 12'h200;
  localparam logic [11:0] OP_SUB = 12'h400;
  localparam logic [11:0] OP_AND = 12'h800;
  localparam logic [11:0] OP_ORR = 12'hC00;
  localparam logic [11:0] FET    = MEMR | IRW | PCW;

  localparam logic [31:0] I_ADD  = 32'h8B020020;
  localparam logic [31:0] I_SUB  = 32'hCB030041;
  localparam logic [31:0] I_AND  = 32'h8A040062;
  localparam logic [31:0] I_ORR  = 32'hAA050083;
  localparam logic [31:0] I_LDUR = 32'hF8408041;
  localparam logic [31:0] I_STUR = 32'hF8010062;
  localparam logic [31:0] I_CBZ  = 32'hB4000103;
  localparam logic [31:0] I_B    = 32'h14000004;
  localparam logic [31:0] I_ILL  = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        memReady;
  logic        isZero;
  logic [1:0]  ALUop;
  logic        aluSrc, reg2Loc, irWrite, pcWrite, pcSrc;
  logic        memRead, memWrite, memToReg, regWrite, halted;

  logic [11:0] exp_q[$];
  string       name_q[$];
  logic        done = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.INSTR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .memReady (memReady),
    .isZero   (isZero),
    .ALUop    (ALUop),
    .aluSrc   (aluSrc),
    .reg2Loc  (reg2Loc),
    .irWrite  (irWrite),
    .pcWrite  (pcWrite),
    .pcSrc    (pcSrc),
    .memRead  (memRead),
    .memWrite (memWrite),
    .memToReg (memToReg),
    .regWrite (regWrite),
    .halted   (halted)
  );

  function automatic logic [11:0] outs();
    return {ALUop, aluSrc, reg2Loc, irWrite, pcWrite, pcSrc,
            memRead, memWrite, memToReg, regWrite, halted};
  endfunction

  // Record one pass/fail result
  task automatic check(input logic ok, input string nm);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL %s: outputs %03h", nm, outs());
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue its expectation
  task automatic step(input logic rn, input logic mr, input logic iz,
                      input logic [31:0] ins, input logic [11:0] ev, input string nm);
    rst_n    = rn;
    memReady = mr;
    isZero   = iz;
    instr    = ins;
    exp_q.push_back(ev);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each queued expectation on the falling edge
  always @(negedge clk) begin
    logic [11:0] ev;
    string       nm;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      nm = name_q.pop_front();
      check(outs() === ev && !(memRead === 1'b1 && memWrite === 1'b1), nm);
    end else if (done) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; memReady = 1'b1; isZero = 1'b0; instr = I_ADD;
    @(posedge clk);
    #1;
    // Reset state and release
    step(0, 1, 0, I_ADD, Z, "reset_idle");
    check(outs() === Z, "direct_reset_all_zero");
    step(1, 1, 0, I_ADD, Z, "idle");

    // ADD: 4 cycles, with one fetch stall first
    step(1, 0, 0, I_ADD, MEMR, "add_fetch_stall");
    step(1, 1, 0, I_ADD, FET,  "add_fetch");
    step(1, 0, 0, I_ADD, Z,    "add_decode");
    step(1, 1, 0, I_ADD, Z,    "add_exec");
    step(1, 1, 0, I_ADD, REGW, "add_wb");

    // LDUR with three memReady-low cycles in MEM
    step(1, 1, 0, I_LDUR, FET,        "ldur_fetch");
    step(1, 1, 0, I_LDUR, Z,          "ldur_decode");
    step(1, 1, 0, I_LDUR, ALUSRC,     "ldur_exec");
    step(1, 0, 0, I_LDUR, MEMR,       "ldur_mem_stall1");
    step(1, 0, 0, I_LDUR, MEMR,       "ldur_mem_stall2");
    step(1, 0, 0, I_LDUR, MEMR,       "ldur_mem_stall3");
    step(1, 1, 0, I_LDUR, MEMR,       "ldur_mem_done");
    step(1, 1, 0, I_LDUR, REGW | M2R, "ldur_wb");

    // CBZ taken then not taken
    step(1, 1, 0, I_CBZ, FET,               "cbz1_fetch");
    step(1, 1, 0, I_CBZ, Z,                 "cbz1_decode");
    step(1, 1, 1, I_CBZ, R2L | PCW | PCSRC, "cbz1_exec_taken");
    step(1, 1, 0, I_CBZ, FET,               "cbz0_fetch");
    step(1, 1, 1, I_CBZ, Z,                 "cbz0_decode");
    step(1, 1, 0, I_CBZ, R2L,               "cbz0_exec_not_taken");

    // Unconditional branch
    step(1, 1, 0, I_B, FET,         "b_fetch");
    step(1, 1, 0, I_B, Z,           "b_decode");
    step(1, 1, 0, I_B, PCW | PCSRC, "b_exec");

    // SUB / AND / ORR / STUR
    step(1, 1, 0, I_SUB, FET,    "sub_fetch");
    step(1, 1, 0, I_SUB, Z,      "sub_decode");
    step(1, 1, 0, I_SUB, OP_SUB, "sub_exec");
    step(1, 1, 0, I_SUB, REGW,   "sub_wb");
    step(1, 1, 0, I_AND, FET,    "and_fetch");
    step(1, 1, 0, I_AND, Z,      "and_decode");
    step(1, 1, 0, I_AND, OP_AND, "and_exec");
    step(1, 1, 0, I_AND, REGW,   "and_wb");
    step(1, 1, 0, I_ORR, FET,    "orr_fetch");
    step(1, 1, 0, I_ORR, Z,      "orr_decode");
    step(1, 1, 0, I_ORR, OP_ORR, "orr_exec");
    step(1, 1, 0, I_ORR, REGW,   "orr_wb");
    step(1, 1, 0, I_STUR, FET,        "stur_fetch");
    step(1, 1, 0, I_STUR, Z,          "stur_decode");
    step(1, 1, 0, I_STUR, ALUSRC,     "stur_exec");
    step(1, 1, 0, I_STUR, MEMW | R2L, "stur_mem");

    // Reset held two cycles in the middle of a stalled STUR memory access
    step(1, 1, 0, I_STUR, FET,        "stur2_fetch");
    step(1, 1, 0, I_STUR, Z,          "stur2_decode");
    step(1, 1, 0, I_STUR, ALUSRC,     "stur2_exec");
    step(1, 0, 0, I_STUR, MEMW | R2L, "stur2_mem_stall");
    step(0, 0, 0, I_STUR, MEMW | R2L, "stur2_mem_rst_edge");
    check(memWrite === 1'b0, "direct_memwrite_drops_on_reset_edge");
    check(outs() === Z, "direct_no_strobe_after_reset_edge");
    step(0, 0, 0, I_STUR, Z,          "rst_idle_held");
    step(1, 0, 0, I_STUR, Z,          "rst_idle_release");
    step(1, 1, 0, I_ADD,  FET,        "post_rst_fetch");
    step(1, 1, 0, I_ADD,  Z,          "post_rst_decode");
    step(1, 1, 0, I_ADD,  Z,          "post_rst_exec");
    step(1, 1, 0, I_ADD,  REGW,       "post_rst_wb");

    // Illegal opcode traps; inputs wiggle but nothing leaves TRAP
    step(1, 1, 0, I_ILL, FET, "ill_fetch");
    step(1, 1, 0, I_ILL, Z,   "ill_decode");
    check(halted === 1'b1, "direct_trap_halted");
    check(memRead === 1'b0 && memWrite === 1'b0, "direct_trap_no_mem");
    check(regWrite === 1'b0 && pcWrite === 1'b0 && irWrite === 1'b0, "direct_trap_no_strobes");
    for (int i = 0; i < 20; i++) begin
      step(1, i[0], i[1], I_ILL, HALT, $sformatf("trap_%0d", i));
      check(memRead === 1'b0 && memWrite === 1'b0, $sformatf("direct_trap_mem_%0d", i));
    end
    step(0, 1, 0, I_ILL, HALT, "trap_rst_edge");
    check(halted === 1'b0, "direct_trap_exit_by_reset");
    step(1, 1, 0, I_ADD, Z,    "trap_exit_idle");
    step(1, 1, 0, I_ADD, FET,  "trap_exit_fetch");

    done = 1'b1;
  end

endmodule
